// File: rtl/pasta_feistel_sbox.sv
// PASTA nonlinear layer: lane-wise Feistel S-box y[0]=x[0], y[i]=x[i]+x[i-1]^2 mod q.
// Modulus is fixed to q = 2^16+1, so squares are reduced as lo16 - hi17 (2^16 == -1 mod q).
// Fully pipelined with a single global stall enable; valid/ready on both sides.
// Optional feature macro PASTA_CUBE_SBOX_EN: adds sbox_sel and a cube S-box (x^3 mod q on
// all lanes). The pipe then grows to 5 stages, and both modes have latency 5.
module pasta_feistel_sbox #(
  parameter int unsigned BITLEN = 17,
  parameter int unsigned Q      = 65537,
  parameter int unsigned S      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
`ifdef PASTA_CUBE_SBOX_EN
  input  logic                sbox_sel,
`endif
  input  logic [BITLEN*S-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITLEN*S-1:0] out_data
);

  // A product of two lanes < q is at most 2^32, so it fits in 2*BITLEN-1 bits.
  localparam int unsigned SqW = 2 * BITLEN - 1;

  typedef logic [BITLEN-1:0] lane_t;
  typedef logic [SqW-1:0]    sq_t;

  // Product of two residues; operands are widened first so the result is never truncated.
  function automatic sq_t mod_mul_raw(input lane_t a, input lane_t b);
    sq_t ea;
    sq_t eb;
    ea = sq_t'(a);
    eb = sq_t'(b);
    return ea * eb;
  endfunction

  // v = hi*2^16 + lo == lo - hi (mod q); one conditional +q brings it into [0, q-1].
  function automatic lane_t mod_reduce(input sq_t v);
    logic [BITLEN:0] diff;
    diff = {1'b0, BITLEN'(v[15:0])} - {1'b0, v[SqW-1:16]};
    if (diff[BITLEN]) begin
      diff = diff + (BITLEN + 1)'(Q);
    end
    return BITLEN'(diff);
  endfunction

  // Sum of two residues with a single conditional subtract.
  function automatic lane_t mod_add(input lane_t a, input lane_t b);
    logic [BITLEN:0] t;
    t = {1'b0, a} + {1'b0, b};
    if (t >= (BITLEN + 1)'(Q)) begin
      t = t - (BITLEN + 1)'(Q);
    end
    return BITLEN'(t);
  endfunction

  lane_t [S-1:0] x_in;
  logic          en;

  assign x_in = in_data;

  // Whole pipe moves together: it advances whenever the output slot is empty or draining.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

`ifdef PASTA_CUBE_SBOX_EN

  // Stage 1: square (own lane for cube, left neighbour for Feistel)
  // Stage 2: reduce square
  // Stage 3: Feistel add, and multiply square by own lane for cube
  // Stage 4: reduce cube, Feistel result carried alongside
  // Stage 5: select result by mode
  logic [4:0]    v_d, v_q;
  logic [3:0]    sel_d, sel_q;
  lane_t [S-1:0] x1_d, x1_q;
  sq_t   [S-1:0] sq1_d, sq1_q;
  lane_t [S-1:0] x2_d, x2_q;
  lane_t [S-1:0] r2_d, r2_q;
  lane_t [S-1:0] f3_d, f3_q;
  sq_t   [S-1:0] m3_d, m3_q;
  lane_t [S-1:0] f4_d, f4_q;
  lane_t [S-1:0] c4_d, c4_q;
  lane_t [S-1:0] y5_d, y5_q;

  // Next-state for every stage; everything holds while the output is stalled.
  always_comb begin
    v_d   = v_q;
    sel_d = sel_q;
    x1_d  = x1_q;
    sq1_d = sq1_q;
    x2_d  = x2_q;
    r2_d  = r2_q;
    f3_d  = f3_q;
    m3_d  = m3_q;
    f4_d  = f4_q;
    c4_d  = c4_q;
    y5_d  = y5_q;
    if (en) begin
      v_d   = {v_q[3:0], in_valid};
      sel_d = {sel_q[2:0], sbox_sel};

      x1_d     = x_in;
      sq1_d[0] = mod_mul_raw(x_in[0], x_in[0]);
      for (int unsigned i = 1; i < S; i++) begin
        sq1_d[i] = sbox_sel ? mod_mul_raw(x_in[i], x_in[i])
                            : mod_mul_raw(x_in[i-1], x_in[i-1]);
      end

      x2_d = x1_q;
      for (int unsigned i = 0; i < S; i++) begin
        r2_d[i] = mod_reduce(sq1_q[i]);
      end

      f3_d[0] = x2_q[0];
      for (int unsigned i = 1; i < S; i++) begin
        f3_d[i] = mod_add(x2_q[i], r2_q[i]);
      end
      for (int unsigned i = 0; i < S; i++) begin
        m3_d[i] = mod_mul_raw(r2_q[i], x2_q[i]);
      end

      f4_d = f3_q;
      for (int unsigned i = 0; i < S; i++) begin
        c4_d[i] = mod_reduce(m3_q[i]);
      end

      y5_d = sel_q[3] ? c4_q : f4_q;
    end
  end

  // Pipeline registers, cleared asynchronously so in-flight vectors are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      sel_q <= '0;
      x1_q  <= '0;
      sq1_q <= '0;
      x2_q  <= '0;
      r2_q  <= '0;
      f3_q  <= '0;
      m3_q  <= '0;
      f4_q  <= '0;
      c4_q  <= '0;
      y5_q  <= '0;
    end else begin
      v_q   <= v_d;
      sel_q <= sel_d;
      x1_q  <= x1_d;
      sq1_q <= sq1_d;
      x2_q  <= x2_d;
      r2_q  <= r2_d;
      f3_q  <= f3_d;
      m3_q  <= m3_d;
      f4_q  <= f4_d;
      c4_q  <= c4_d;
      y5_q  <= y5_d;
    end
  end

  assign out_valid = v_q[4];
  assign out_data  = y5_q;

`else

  // Stage 1: square left neighbour; stage 2: reduce; stage 3: add own lane.
  // Lane 0 has no left neighbour, so the square/reduce arrays start at lane 1.
  logic [2:0]    v_d, v_q;
  lane_t [S-1:0] x1_d, x1_q;
  sq_t   [S-1:1] sq1_d, sq1_q;
  lane_t [S-1:0] x2_d, x2_q;
  lane_t [S-1:1] r2_d, r2_q;
  lane_t [S-1:0] y3_d, y3_q;

  // Next-state for every stage; everything holds while the output is stalled.
  always_comb begin
    v_d   = v_q;
    x1_d  = x1_q;
    sq1_d = sq1_q;
    x2_d  = x2_q;
    r2_d  = r2_q;
    y3_d  = y3_q;
    if (en) begin
      v_d = {v_q[1:0], in_valid};

      x1_d = x_in;
      for (int unsigned i = 1; i < S; i++) begin
        sq1_d[i] = mod_mul_raw(x_in[i-1], x_in[i-1]);
      end

      x2_d = x1_q;
      for (int unsigned i = 1; i < S; i++) begin
        r2_d[i] = mod_reduce(sq1_q[i]);
      end

      y3_d[0] = x2_q[0];
      for (int unsigned i = 1; i < S; i++) begin
        y3_d[i] = mod_add(x2_q[i], r2_q[i]);
      end
    end
  end

  // Pipeline registers, cleared asynchronously so in-flight vectors are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      x1_q  <= '0;
      sq1_q <= '0;
      x2_q  <= '0;
      r2_q  <= '0;
      y3_q  <= '0;
    end else begin
      v_q   <= v_d;
      x1_q  <= x1_d;
      sq1_q <= sq1_d;
      x2_q  <= x2_d;
      r2_q  <= r2_d;
      y3_q  <= y3_d;
    end
  end

  assign out_valid = v_q[2];
  assign out_data  = y3_q;

`endif

endmodule

// File: tb/tb_pasta_feistel_sbox.sv
// Bench for pasta_feistel_sbox: directed vector table, backpressure, throughput, reset.
module tb_pasta_feistel_sbox;
  localparam int unsigned BITLEN = 17;
  localparam int unsigned Q      = 65537;
  localparam int unsigned S      = 32;
  localparam int unsigned W      = BITLEN * S;
`ifdef PASTA_CUBE_SBOX_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  typedef logic [W-1:0] vec_t;
  typedef struct {
    vec_t  x;
    vec_t  y;
    string name;
  } entry_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  vec_t in_data;
  vec_t out_data;
`ifdef PASTA_CUBE_SBOX_EN
  logic sbox_sel;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pasta_feistel_sbox #(
    .BITLEN(BITLEN),
    .Q     (Q),
    .S     (S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
`ifdef PASTA_CUBE_SBOX_EN
    .sbox_sel (sbox_sel),
`endif
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  task automatic check(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t put(input vec_t v, input int lane, input int unsigned val);
    vec_t r;
    r = v;
    r[lane*BITLEN +: BITLEN] = val[BITLEN-1:0];
    return r;
  endfunction

  // Golden model with plain wide integer arithmetic.
  function automatic vec_t model(input vec_t x, input bit cube);
    vec_t y;
    longint unsigned a, p, r;
    y = '0;
    for (int i = 0; i < int'(S); i++) begin
      a = {47'b0, x[i*BITLEN +: BITLEN]};
      if (cube) begin
        r = (((a * a) % 64'(Q)) * a) % 64'(Q);
      end else if (i == 0) begin
        r = a;
      end else begin
        p = {47'b0, x[(i-1)*BITLEN +: BITLEN]};
        r = (a + p * p) % 64'(Q);
      end
      y[i*BITLEN +: BITLEN] = r[BITLEN-1:0];
    end
    return y;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v = '0;
    for (int i = 0; i < int'(S); i++) begin
      if ($urandom_range(0, 15) == 0) v = put(v, i, 65536);
      else v = put(v, i, $urandom_range(0, Q - 1));
    end
    return v;
  endfunction

  // Send one vector, wait for its result, check data and latency.
  task automatic send_one(input vec_t x, input vec_t exp, input string name);
    int lat;
    in_valid = 1'b1;
    in_data  = x;
`ifdef PASTA_CUBE_SBOX_EN
    sbox_sel = 1'b0;
`endif
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 20);
    check({name, " data"}, out_data, exp);
    check({name, " latency"}, vec_t'(lat), vec_t'(LAT));
  endtask

  entry_t tbl[8];
  vec_t   bp_x[4];
  vec_t   bp_y[4];
  vec_t   tp_x[100];
  vec_t   tp_y[100];

  initial begin
    int sent, recv, first_out, last_out, stall_seen, not_ready, late;
    vec_t v;

    // Directed table with hand-computed results.
    for (int k = 0; k < 8; k++) begin
      tbl[k].x = '0;
      tbl[k].y = '0;
    end
    tbl[0].name = "basic";
    tbl[0].x = put(put(tbl[0].x, 0, 2), 1, 3);
    tbl[0].y = put(put(put(tbl[0].y, 0, 2), 1, 7), 2, 9);
    tbl[1].name = "wrap";
    for (int i = 0; i < int'(S); i++) tbl[1].x = put(tbl[1].x, i, 65536);
    tbl[1].y = put(tbl[1].y, 0, 65536);
    tbl[2].name = "zeros";
    tbl[3].name = "ones";
    for (int i = 0; i < int'(S); i++) begin
      tbl[3].x = put(tbl[3].x, i, 1);
      tbl[3].y = put(tbl[3].y, i, (i == 0) ? 1 : 2);
    end
    tbl[4].name = "lane0_max";
    tbl[4].x = put(tbl[4].x, 0, 65536);
    tbl[4].y = put(put(tbl[4].y, 0, 65536), 1, 1);
    tbl[5].name = "mid_lanes";
    tbl[5].x = put(put(tbl[5].x, 5, 257), 6, 65535);
    tbl[5].y = put(put(put(tbl[5].y, 5, 257), 6, 510), 7, 4);
    tbl[6].name = "top_lane";
    tbl[6].x = put(put(tbl[6].x, 30, 3), 31, 65536);
    tbl[6].y = put(put(tbl[6].y, 30, 3), 31, 8);
    tbl[7].name = "sq_65536";
    tbl[7].x = put(tbl[7].x, 10, 256);
    tbl[7].y = put(put(tbl[7].y, 10, 256), 11, 65536);

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef PASTA_CUBE_SBOX_EN
    sbox_sel  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", vec_t'(out_valid), vec_t'(0));
    check("reset out_data", out_data, '0);
    rst = 1'b0;
    #1;
    check("reset in_ready", vec_t'(in_ready), vec_t'(1));

    for (int k = 0; k < 8; k++) begin
      send_one(tbl[k].x, tbl[k].y, tbl[k].name);
    end

`ifdef PASTA_CUBE_SBOX_EN
    // Cube then Feistel back-to-back; both take the same latency.
    @(posedge clk);
    #1;
    recv     = 0;
    in_valid = 1'b1;
    sbox_sel = 1'b1;
    in_data  = put(put('0, 0, 2), 1, 65536);
    for (int c = 1; c <= 20 && recv < 2; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        sbox_sel = 1'b0;
        in_data  = tbl[0].x;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        if (recv == 0) begin
          check("cube data", out_data, put(put('0, 0, 8), 1, 65536));
          check("cube latency", vec_t'(c), vec_t'(LAT));
        end else begin
          check("mixed feistel data", out_data, tbl[0].y);
          check("mixed feistel latency", vec_t'(c), vec_t'(LAT + 1));
        end
        recv++;
      end
    end
    check("cube outputs", vec_t'(recv), vec_t'(2));
`endif

    // Backpressure: 4 vectors, output blocked for the first 8 cycles.
    for (int j = 0; j < 4; j++) begin
      bp_x[j] = rand_vec();
      bp_y[j] = model(bp_x[j], 1'b0);
    end
    @(posedge clk);
    #1;
    sent = 0;
    recv = 0;
    stall_seen = 0;
    for (int c = 0; c < 80 && recv < 4; c++) begin
      out_ready = (c >= 8);
      in_valid  = (sent < 4);
      if (sent < 4) in_data = bp_x[sent];
      #1;
      if (out_valid && !out_ready) begin
        stall_seen++;
        check("stall in_ready", vec_t'(in_ready), vec_t'(0));
      end
      if (out_valid) check("bp data", out_data, bp_y[recv]);
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) recv++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("bp sent", vec_t'(sent), vec_t'(4));
    check("bp received", vec_t'(recv), vec_t'(4));
    check("bp stall cycles", vec_t'(stall_seen >= 5), vec_t'(1));
    #1;
    check("bp no duplicate", vec_t'(out_valid), vec_t'(0));

    // Throughput: 100 vectors with the output always ready.
    for (int j = 0; j < 100; j++) begin
      tp_x[j] = rand_vec();
      tp_y[j] = model(tp_x[j], 1'b0);
    end
    out_ready = 1'b1;
    sent = 0;
    recv = 0;
    first_out = -1;
    last_out = -1;
    not_ready = 0;
    for (int c = 0; c < 400 && recv < 100; c++) begin
      in_valid = (sent < 100);
      if (sent < 100) in_data = tp_x[sent];
      #1;
      if (!in_ready) not_ready++;
      if (in_valid && in_ready) sent++;
      if (out_valid) begin
        check("tp data", out_data, tp_y[recv]);
        if (first_out < 0) first_out = c;
        last_out = c;
        recv++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("tp received", vec_t'(recv), vec_t'(100));
    check("tp consecutive", vec_t'(last_out - first_out), vec_t'(99));
    check("tp in_ready", vec_t'(not_ready), vec_t'(0));

    // Reset while results are in flight.
    in_valid = 1'b1;
    in_data  = tbl[3].x;
    late = 0;
    do begin
      @(posedge clk);
      #1;
      late++;
    end while (!out_valid && late < 20);
    check("pre-reset out_valid", vec_t'(out_valid), vec_t'(1));
    rst = 1'b1;
    #1;
    check("async reset out_valid", vec_t'(out_valid), vec_t'(0));
    check("async reset out_data", out_data, '0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post-reset in_ready", vec_t'(in_ready), vec_t'(1));
    late = 0;
    for (int c = 0; c < LAT + 3; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) late++;
    end
    check("no stale output", vec_t'(late), vec_t'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
